// File: rtl/key_schedule_engine.sv
// key_schedule_engine: AES (FIPS-197) key expansion for 128/192/256-bit keys.
// One 32-bit expanded word is produced per cycle from a sliding window of the
// last eight words; words are packed four at a time into a round key that is
// offered on a valid/ready handshake.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             begin expansion (sampled in IDLE only)
//   key_len_i           00=128, 01=192, 10=256, 11=illegal
//   key_in_i            MSB-aligned cipher key
//   busy_o              expansion in progress
//   rk_valid_o/rk_ready_i  round key handshake
//   rk_data_o, rk_idx_o round key (w[4r] in [127:96]) and round number r
//   done_o              pulse after the final round key is accepted
//   err_o               pulse after a start with an unsupported key length

// aes_sbox: combinational AES S-box (GF(2^8) inverse followed by affine map).
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // Inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0).
    always_comb begin
        sq  = data_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_schedule_engine #(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter bit          SKIP_RK0     = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] key_in_i,
    output logic         busy_o,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_data_o,
    output logic [3:0]   rk_idx_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RK_W   = 128;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   key_q [8];
    logic [WORD_W-1:0]   key_d [8];
    logic [WORD_W-1:0]   win_q [8];
    logic [WORD_W-1:0]   win_d [8];
    logic [3*WORD_W-1:0] asm_q, asm_d;
    logic [1:0]          klen_q, klen_d;
    logic [5:0]          wcnt_q, wcnt_d;
    logic [2:0]          mcnt_q, mcnt_d;
    logic [7:0]          rcon_q, rcon_d;
    logic                busy_q, busy_d;
    logic                rk_valid_q, rk_valid_d;
    logic [RK_W-1:0]     rk_data_q, rk_data_d;
    logic [3:0]          rk_idx_q, rk_idx_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [3:0]          nk;
    logic [5:0]          last_idx;
    logic [WORD_W-1:0]   prev_w, far_w, sb_in, sb_out, t_word, w_new;
    logic                len_legal;

    // Nk = 4/6/8; index of the final word is 43/51/59.
    assign nk       = 4'd4 + {1'b0, klen_q, 1'b0};
    assign last_idx = 6'd43 + 6'({klen_q, 3'b000});
    assign prev_w   = win_q[0];
    assign far_w    = win_q[3'(nk - 4'd1)];
    assign len_legal = (key_len_i != 2'b11) &&
                       ((32'd128 + 32'd64 * 32'(key_len_i)) <= 32'(MAX_KEY_BITS));

    // RotWord only on the Nk boundary; the same S-box bank serves the Nk==8 i%8==4 case.
    assign sb_in = (mcnt_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i (sb_in[8*b +: 8]),
            .data_o (sb_out[8*b +: 8])
        );
    end

    always_comb begin
        if (mcnt_q == 3'd0)                     t_word = sb_out ^ {rcon_q, 24'h0};
        else if (nk == 4'd8 && mcnt_q == 3'd4)  t_word = sb_out;
        else                                    t_word = prev_w;
        w_new = (wcnt_q < 6'(nk)) ? key_q[wcnt_q[2:0]] : (far_w ^ t_word);
    end

    // Next-state and output logic.
    always_comb begin
        logic group_end;
        logic emit;
        logic stall;

        state_d    = state_q;
        key_d      = key_q;
        win_d      = win_q;
        asm_d      = asm_q;
        klen_d     = klen_q;
        wcnt_d     = wcnt_q;
        mcnt_d     = mcnt_q;
        rcon_d     = rcon_q;
        busy_d     = busy_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        group_end  = (wcnt_q[1:0] == 2'b11);
        emit       = !(SKIP_RK0 && wcnt_q[5:2] == 4'd0);
        stall      = group_end && emit && rk_valid_q && !rk_ready_i;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_legal) begin
                        state_d = S_EXPAND;
                        busy_d  = 1'b1;
                        klen_d  = key_len_i;
                        wcnt_d  = 6'd0;
                        mcnt_d  = 3'd0;
                        rcon_d  = 8'h01;
                        for (int k = 0; k < 8; k++) key_d[k] = key_in_i[255-32*k -: 32];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EXPAND: begin
                if (rk_valid_q && rk_ready_i) rk_valid_d = 1'b0;
                if (!stall) begin
                    win_d[0] = w_new;
                    for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
                    if (!group_end) begin
                        asm_d = {asm_q[2*WORD_W-1:0], w_new};
                    end else if (emit) begin
                        rk_data_d  = {asm_q, w_new};
                        rk_idx_d   = wcnt_q[5:2];
                        rk_valid_d = 1'b1;
                    end
                    if (wcnt_q >= 6'(nk) && mcnt_q == 3'd0)
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    mcnt_d = (mcnt_q == 3'(nk - 4'd1)) ? 3'd0 : mcnt_q + 3'd1;
                    wcnt_d = wcnt_q + 6'd1;
                    if (wcnt_q == last_idx) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (rk_valid_q && rk_ready_i) begin
                    rk_valid_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            for (int k = 0; k < 8; k++) begin
                key_q[k] <= '0;
                win_q[k] <= '0;
            end
            asm_q      <= '0;
            klen_q     <= 2'd0;
            wcnt_q     <= 6'd0;
            mcnt_q     <= 3'd0;
            rcon_q     <= 8'h01;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            win_q      <= win_d;
            asm_q      <= asm_d;
            klen_q     <= klen_d;
            wcnt_q     <= wcnt_d;
            mcnt_q     <= mcnt_d;
            rcon_q     <= rcon_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy_o     = busy_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_data_o  = rk_data_q;
    assign rk_idx_o   = rk_idx_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_key_schedule_engine.sv
// Testbench for key_schedule_engine: published FIPS-197 vectors, a word-level
// reference expansion, random keys with random backpressure, error/abort cases.
module tb_key_schedule_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         rk_ready;
    logic         busy, rk_valid, done, err;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    key_schedule_engine dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .key_len_i  (key_len),
        .key_in_i   (key_in),
        .busy_o     (busy),
        .rk_valid_o (rk_valid),
        .rk_ready_i (rk_ready),
        .rk_data_o  (rk_data),
        .rk_idx_o   (rk_idx),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;
    vec_t vecs [5];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box table by brute-force inverse search and bitwise affine transform.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            logic [7:0] c = 8'h63;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
        int nk = 4 + 2 * int'(kl);
        int nr = 10 + 2 * int'(kl);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gf_mul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full expansion; pct = chance (percent) of rk_ready per cycle.
    task automatic run_key(input logic [1:0] kl, input logic [255:0] key, input int pct,
                           input bit timed, input bit inject);
        int nr = 10 + 2 * int'(kl);
        int cyc = 0;
        int nexp = 0;
        bit fin = 0;
        bit prev_stall = 0;
        bit rdy;
        logic [127:0] prev_data = '0;
        logic [3:0]   prev_idx = '0;
        model_expand(kl, key);
        @(negedge clk);
        key_len = kl; key_in = key; start = 1'b1; rk_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; key_in = ~key; key_len = 2'd3;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", 256'(busy), 256'(1));
            if (prev_stall)
                check("stall_stable", {127'h0, rk_valid, rk_idx, rk_data}, {127'h0, 1'b1, prev_idx, prev_data});
            rdy = ($urandom_range(99) < 32'(pct));
            rk_ready = rdy;
            if (inject && cyc == 9) begin
                start = 1'b1; key_len = 2'd2; key_in = {8{$urandom}};
            end else begin
                start = 1'b0;
            end
            if (rk_valid && rdy) begin
                check("rk_idx", 256'(rk_idx), 256'(nexp));
                check("rk_data", 256'(rk_data), 256'(exp_rk[nexp]));
                if (timed) check("accept_cycle", 256'(cyc), 256'(4 + 4*nexp));
                got_rk[nexp] = rk_data;
                if (nexp == nr) fin = 1;
                nexp++;
            end
            prev_stall = rk_valid && !rdy;
            prev_data  = rk_data;
            prev_idx   = rk_idx;
            @(posedge clk);
            cyc++;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL run_timeout actual=%0d keys required=%0d keys", nexp, nr + 1);
        end
        @(negedge clk);
        start = 1'b0; rk_ready = 1'b0;
        check("done_pulse", 256'({done, busy, rk_valid}), 256'(3'b100));
        @(negedge clk);
        check("done_end", 256'({done, busy, rk_valid}), 256'(3'b000));
    endtask

    initial begin
        int waitc;
        logic [1:0]   rkl;
        logic [255:0] rkey;
        build_sbox();
        vecs[0] = '{2'd0, K128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{2'd0, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{2'd0, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{2'd1, K192, 12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[4] = '{2'd2, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e};

        rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {119'h0, busy, rk_valid, done, err, rk_idx, rk_data},
              256'h0);
        rst = 1'b0;

        // Published vectors, rk_ready held high.
        for (int v = 0; v < 5; v++) begin
            run_key(vecs[v].kl, vecs[v].key, 100, 1'b1, 1'b0);
            check($sformatf("vector%0d_rk%0d", v, vecs[v].idx), 256'(got_rk[vecs[v].idx]), 256'(vecs[v].rk));
        end

        // Backpressure with a start issued while busy.
        run_key(2'd0, K128, 30, 1'b0, 1'b1);
        check("bp_rk1", 256'(got_rk[1]), 256'(vecs[1].rk));
        check("bp_rk10", 256'(got_rk[10]), 256'(vecs[2].rk));

        // Illegal key length.
        @(negedge clk);
        start = 1'b1; key_len = 2'd3; key_in = K128;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("err_pulse", 256'({err, busy}), 256'(2'b10));
        @(negedge clk);
        check("err_end", 256'({err, busy, rk_valid}), 256'(3'b000));

        // Reset in the middle of an expansion, with start asserted alongside.
        @(negedge clk);
        start = 1'b1; key_len = 2'd0; key_in = K128; rk_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!(rk_valid && rk_idx == 4'd5) && waitc < 200);
        if (waitc >= 200) begin
            checks++; errors++;
            $display("FAIL wait_rk5 actual=timeout required=rk_idx 5");
        end
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_outputs", {119'h0, busy, rk_valid, done, err, rk_idx, rk_data}, 256'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_idle", 256'({busy, rk_valid, done}), 256'(3'b000));
        end
        run_key(2'd0, K128, 100, 1'b1, 1'b0);

        // Random keys of every length with random backpressure.
        for (int n = 0; n < 6; n++) begin
            rkl  = 2'(n % 3);
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_key(rkl, rkey, 20 + int'($urandom_range(80)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_schedule_engine.md
KEY_SCHEDULE_ENGINE -- requirements
Module: key_schedule_engine

Interface
REQ-001 SHALL have parameter MAX_KEY_BITS, default 256, the largest key length accepted (128, 192 or 256); key_len codes above it are illegal.
REQ-002 SHALL have parameter SKIP_RK0, default 0; when 1, round key 0 (the cipher key itself) is not emitted and rk_idx starts at 1.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin expansion; sampled only in IDLE.
REQ-006 key_len  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal; sampled with start.
REQ-007 key_in  input  256  cipher key, MSB-aligned (128-bit key in [255:128], 192-bit in [255:64]); sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 rk_valid  output  1  rk_data/rk_idx hold a valid round key.
REQ-010 rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready at a rising edge.
REQ-011 rk_data  output  128  round key, word w[4r] in [127:96].
REQ-012 rk_idx  output  4  round number r of rk_data.
REQ-013 done  output  1  one-cycle pulse after the last round key is accepted.
REQ-014 err  output  1  one-cycle pulse when start is issued with an illegal key_len.

Function
REQ-015 SHALL implement FIPS-197 key expansion with Nk=4/6/8 and Nr=10/12/14, producing 4*(Nr+1) words (44/52/60).
REQ-016 SHALL generate exactly one 32-bit word w[i] per non-stalled EXPAND cycle, using a sliding window of the last 8 words and 4 instances of the existing sbox module.
REQ-017 For i<Nk, w[i] SHALL be the corresponding key_in word; for i>=Nk, w[i] = w[i-Nk] ^ t.
REQ-018 t SHALL be SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod Nk == 0; SubWord(w[i-1]) when Nk==8 and i mod Nk == 4; else w[i-1].
REQ-019 rcon SHALL be an 8-bit register set to 8'h01 at start and updated by GF(2^8) xtime (reduction 8'h1b) after each use, giving 01,02,04,...,80,1b,36.
REQ-020 States: IDLE, EXPAND, FLUSH; IDLE->EXPAND on start with legal key_len; EXPAND->FLUSH after the last word is generated; FLUSH->IDLE when the last round key is accepted.
REQ-021 Words SHALL be packed into a 4-word assembly register; the 4th word of a group loads rk_data, sets rk_valid and sets rk_idx to the group number.
REQ-022 Generation of a group-completing word SHALL stall while rk_valid && !rk_ready; the first three words of the next group SHALL proceed during the stall.
REQ-023 rk_data and rk_idx SHALL remain stable while rk_valid && !rk_ready.
REQ-024 Latency: start at edge T leads to rk_valid high after edge T+4 (round key 0, or round key 1 when SKIP_RK0=1, after edge T+8); with rk_ready held high, throughput SHALL be one round key per 4 cycles.
REQ-025 On accept of the final round key (rk_idx==Nr), rk_valid SHALL drop, done SHALL pulse in the next cycle, and busy SHALL fall with it.
REQ-026 start while busy SHALL be ignored, with no effect on key, key_len or progress.
REQ-027 An illegal key_len, or a key length above MAX_KEY_BITS, SHALL pulse err in the next cycle and keep the state at IDLE.
REQ-028 Word counter width SHALL be 6 bits; Nk-modulo tracking SHALL use a separate 3-bit counter wrapping at Nk-1, with no divider.

Reset
REQ-029 On rst: state=IDLE; busy=0, rk_valid=0, done=0, err=0, rk_data=0, rk_idx=0, rcon=8'h01, counters=0.
REQ-030 rst asserted mid-expansion SHALL abort in the same edge; a pending round key is discarded, and done does not pulse.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 AES-128 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 -> rk_idx1 = a0fafe17_88542cb1_23a33939_2a6c7605; rk_idx10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; done 1 cycle later.
REQ-033 AES-192 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> 13 round keys; rk_idx12 = e98ba06f_448c773c_8ecc7204_01002202.
REQ-034 AES-256 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> 15 round keys; rk_idx14 = fe4890d1_e6188d0b_046df344_706c631e.
REQ-035 Backpressure: random rk_ready (about 30% high) -> identical key sequence to the REQ-032 run; rk_data is stable during every stall; no index is skipped or repeated.
REQ-036 key_len=11 -> err pulses once, busy stays 0; start during busy -> ignored; rst at round 5 -> all outputs return to reset values next cycle, and a new start then completes normally.
